// File: rtl/tick_debouncer_if.sv
// Signal bundle between the switch/tick source and the debouncer.
// tick_in and the db_* strobes are one-clk pulses; there is no back-pressure.
interface tick_debouncer_if #(
    parameter int CW = 4
);
    logic          tick_in;
    logic          sw;
    logic          db_level;
    logic          db_rise;
    logic          db_fall;
    logic          busy;
    // Debug view of the FSM: 0=ZERO 1=WAIT1 2=ONE 3=WAIT0, plus the tick counter.
    logic [1:0]    dbg_state;
    logic [CW-1:0] dbg_cnt;

    modport master (
        output tick_in,
        output sw,
        input  db_level,
        input  db_rise,
        input  db_fall,
        input  busy,
        input  dbg_state,
        input  dbg_cnt
    );

    modport slave (
        input  tick_in,
        input  sw,
        output db_level,
        output db_rise,
        output db_fall,
        output busy,
        output dbg_state,
        output dbg_cnt
    );
endinterface

// File: rtl/tick_debouncer.sv
// Switch debouncer: 2-flop synchroniser followed by a 4-state FSM that requires
// STABLE_TICKS consecutive tick_in samples of a new level before db_level moves.
module tick_debouncer #(
    parameter int STABLE_TICKS = 3,
    parameter int CW           = 4
) (
    input  logic            clk,
    input  logic            reset,
    tick_debouncer_if.slave bus
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(STABLE_TICKS - 1);

    logic [1:0]    sync_q;
    logic          sw_s;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          db_level_q;
    logic          db_rise_q;
    logic          db_fall_q;
    logic          busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.sw};
        end
    end

    assign sw_s = sync_q[1];

    // Outputs are updated alongside the state so they always match state_q;
    // an abort (level back to the stable value) takes priority over a tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ZERO;
            cnt_q      <= '0;
            db_level_q <= 1'b0;
            db_rise_q  <= 1'b0;
            db_fall_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            db_rise_q <= 1'b0;
            db_fall_q <= 1'b0;
            case (state_q)
                ZERO: begin
                    if (sw_s) begin
                        state_q <= WAIT1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT1: begin
                    if (!sw_s) begin
                        state_q <= ZERO;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (bus.tick_in) begin
                        if (cnt_q == LAST_CNT) begin
                            state_q    <= ONE;
                            cnt_q      <= '0;
                            busy_q     <= 1'b0;
                            db_level_q <= 1'b1;
                            db_rise_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ONE: begin
                    if (!sw_s) begin
                        state_q <= WAIT0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT0: begin
                    if (sw_s) begin
                        state_q <= ONE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (bus.tick_in) begin
                        if (cnt_q == LAST_CNT) begin
                            state_q    <= ZERO;
                            cnt_q      <= '0;
                            busy_q     <= 1'b0;
                            db_level_q <= 1'b0;
                            db_fall_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= ZERO;
                    cnt_q      <= '0;
                    busy_q     <= 1'b0;
                    db_level_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.db_level  = db_level_q;
    assign bus.db_rise   = db_rise_q;
    assign bus.db_fall   = db_fall_q;
    assign bus.busy      = busy_q;
    assign bus.dbg_state = state_q;
    assign bus.dbg_cnt   = cnt_q;

endmodule

// File: doc/tick_debouncer.md
Name: tick_debouncer

Overview:
- Debounces one raw mechanical switch input, sampling it on a slow enable tick.
- Upstream stage: the free-running binary counter's max_tick output drives tick_in, one pulse every 2**N clk cycles.
- Outputs: a clean level plus single-cycle rise/fall strobes for downstream control logic.
- All logic runs in the clk domain; the raw switch is synchronised internally.

Parameters:
- STABLE_TICKS, 3, consecutive tick_in samples of a stable new level required before the output changes; legal range 1..15.
- CW, 4, width of the internal tick counter; must satisfy 2**CW > STABLE_TICKS.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- tick_in  input  1  sample enable, one clk wide, from the upstream counter's max_tick.
- sw  input  1  raw asynchronous switch input.
- db_level  output  1  debounced switch level.
- db_rise  output  1  one-clk pulse when db_level goes 0->1.
- db_fall  output  1  one-clk pulse when db_level goes 1->0.
- busy  output  1  high while a level change is being qualified (state WAIT1 or WAIT0).

Behaviour:
- Reset is clk reset, asynchronous, active-high. While reset is high:
  - state = ZERO, cnt = 0, both synchroniser flops = 0.
  - db_level = 0, db_rise = 0, db_fall = 0, busy = 0.
- Synchroniser: sw passes through 2 flops to give sw_s, adding 2 clk of latency. All FSM decisions use sw_s only.
- All outputs are registered.
- FSM states, evaluated each clk edge:
  - ZERO: if sw_s=1, go to WAIT1 with cnt<=0. A tick_in in this cycle is not counted.
  - WAIT1:
    - if sw_s=0, go to ZERO with cnt<=0. The abort wins over a simultaneous tick_in.
    - else if tick_in=1 and cnt==STABLE_TICKS-1, go to ONE with cnt<=0.
    - else if tick_in=1, cnt<=cnt+1.
    - else hold.
  - ONE: if sw_s=0, go to WAIT0 with cnt<=0.
  - WAIT0: mirror of WAIT1 with levels swapped. Abort returns to ONE; qualification goes to ZERO.
- Output timing:
  - db_level is 1 exactly when the registered state is ONE or WAIT0.
  - db_rise = 1 for exactly the one clk in which the state first reads ONE after WAIT1.
  - db_fall = 1 for exactly the one clk in which the state first reads ZERO after WAIT0.
  - db_rise and db_fall are never high together.
  - busy = 1 exactly when the registered state is WAIT1 or WAIT0.
- Latency: a level change requires STABLE_TICKS tick_in pulses observed in the WAIT state. From sw stable to the output change takes 2 sync cycles + 1 FSM cycle + the tick wait. Worst case is 3 + STABLE_TICKS*P clk, where P is the tick period.
- Boundary conditions:
  - STABLE_TICKS=1: the first tick_in seen in WAIT1 or WAIT0 qualifies the change.
  - tick_in held continuously high is legal: qualification completes after STABLE_TICKS clk in the WAIT state.
  - A glitch shorter than 2 clk may be lost in the synchroniser; this is acceptable.
  - A glitch that reaches sw_s returns the FSM to its previous stable state, with no output strobe and db_level unchanged.
  - cnt never exceeds STABLE_TICKS-1 and never wraps.
  - Reset mid-qualification: the FSM returns to ZERO with no strobe.
  - If sw is high when reset deasserts, the FSM re-qualifies through WAIT1 and issues db_rise after STABLE_TICKS ticks.
  - A tick_in during ZERO or ONE is ignored.

Test Plan:
1. Reset and idle check:
   - Stimulus: assert reset for 3 clk with sw=1, then deassert.
   - Response: all outputs 0 during reset. busy=1 from clk 3 after deassert. With tick_in every 4 clk and STABLE_TICKS=3, db_level=1 and db_rise=1 for one clk within 3+12 clk of release.
2. Clean press:
   - Stimulus: sw 0->1 and held; tick_in every 4 clk.
   - Response: db_rise exactly once; db_level stays 1; db_fall stays 0.
3. Bounce rejection:
   - Stimulus: db_level=1. Toggle sw 1/0 every 6 clk for 40 clk with ticks every 4 clk, then settle at 1.
   - Response: db_level stays 1 throughout; no db_fall and no db_rise pulses; busy toggles.
4. Abort beats tick:
   - Stimulus: in WAIT1 with cnt=2 (STABLE_TICKS=3), sw_s falls in the same clk as tick_in.
   - Response: next state ZERO; no db_rise; cnt=0.
5. Release:
   - Stimulus: from ONE, sw 1->0 held.
   - Response: db_fall for one clk after 3 ticks; db_level=0.
6. Reset mid-qualification and continuous tick:
   - Reset mid-qualification: reset pulse asserted in WAIT0. Response: immediate db_level=0; no db_fall pulse.
   - Continuous tick: tick_in tied high with STABLE_TICKS=1. Response: db_rise 4 clk after the sw edge.
